// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: PE register map and flit field layout.
package cardinal_nic_pkg;

    localparam int FLIT_W = 64;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    localparam int VC_BIT    = 63;
    localparam int XDIR_BIT  = 62;
    localparam int YDIR_BIT  = 61;
    localparam int HOPX_MSB  = 55;
    localparam int HOPX_LSB  = 52;
    localparam int HOPY_MSB  = 51;
    localparam int HOPY_LSB  = 48;
    localparam int PAYLOAD_W = 48;

    localparam int DROP_CNT_LSB = 8;
    localparam int DROP_CNT_MSB = 15;

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry flit buffer with full flag; load sets full, clear empties it (data retained).
module nic_chan_buf #(
    parameter int W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_clear,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    logic [W-1:0] r_data;
    logic         r_full;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/cardinal_nic.sv
// PE <-> router network interface: register-mapped input/output flit buffers.
// Optional macro NIC_DROP_CNT_EN adds a saturating dropped-write counter in status bits [15:8].
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int FLIT_W = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [FLIT_W-1:0] d_in,
    output logic [FLIT_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_si,
    input  logic              net_ri,
    output logic [FLIT_W-1:0] net_di,
    input  logic              net_so,
    output logic              net_ro,
    input  logic [FLIT_W-1:0] net_do,
    input  logic              net_polarity
);

    logic              w_rd;
    logic              w_wr;
    logic              w_in_full;
    logic [FLIT_W-1:0] w_in_data;
    logic              w_in_load;
    logic              w_in_clear;
    logic              w_out_full;
    logic [FLIT_W-1:0] w_out_data;
    logic              w_out_wr;
    logic              w_out_load;
    logic [FLIT_W-1:0] w_in_stat;
    logic [FLIT_W-1:0] w_out_stat;
    logic [FLIT_W-1:0] r_d_out;

    assign w_rd = nicEn && !nicWrEn;
    assign w_wr = nicEn && nicWrEn;

    // Load and clear are mutually exclusive per channel: load needs empty, clear needs full.
    assign w_in_load  = net_so && !w_in_full;
    assign w_in_clear = w_rd && (addr == ADDR_IN_BUF) && w_in_full;

    assign w_out_wr   = w_wr && (addr == ADDR_OUT_BUF);
    assign w_out_load = w_out_wr && !w_out_full;

    nic_chan_buf #(.W(FLIT_W)) u_in_buf (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_in_load),
        .i_data  (net_do),
        .i_clear (w_in_clear),
        .o_data  (w_in_data),
        .o_full  (w_in_full)
    );

    nic_chan_buf #(.W(FLIT_W)) u_out_buf (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_out_load),
        .i_data  (d_in),
        .i_clear (net_si),
        .o_data  (w_out_data),
        .o_full  (w_out_full)
    );

    assign net_ro = !w_in_full;
    assign net_di = w_out_data;
    assign net_si = w_out_full && net_ri && (w_out_data[VC_BIT] == net_polarity);

`ifdef NIC_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_out_wr && w_out_full && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        w_in_stat     = '0;
        w_out_stat    = '0;
        w_in_stat[0]  = w_in_full;
        w_out_stat[0] = w_out_full;
`ifdef NIC_DROP_CNT_EN
        w_in_stat[DROP_CNT_MSB:DROP_CNT_LSB]  = r_drop_cnt;
        w_out_stat[DROP_CNT_MSB:DROP_CNT_LSB] = r_drop_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            case (addr)
                ADDR_IN_BUF:   r_d_out <= w_in_data;
                ADDR_IN_STAT:  r_d_out <= w_in_stat;
                ADDR_OUT_STAT: r_d_out <= w_out_stat;
                default:       r_d_out <= '0;
            endcase
        end
    end

    assign d_out = r_d_out;

endmodule
